// File: rtl/sweep_sequencer.sv
// Steps the generator's frequency select through a programmed table of
// (code, dwell) entries; single-pass or looping, with start/stop and done pulse.
module sweep_sequencer #(
    parameter int          DEPTH     = 8,
    parameter int          CODE_W    = 4,
    parameter int          DWELL_W   = 16,
    parameter int unsigned PARK_CODE = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cfg_we,
    input  logic [$clog2(DEPTH)-1:0]   cfg_addr,
    input  logic [CODE_W-1:0]          cfg_code,
    input  logic [DWELL_W-1:0]         cfg_dwell,
    input  logic [$clog2(DEPTH):0]     cfg_len,
    input  logic                       loop,
    input  logic                       start,
    input  logic                       stop,
    output logic [CODE_W-1:0]          freq_value,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH)-1:0]   step_idx,
    output logic                       step_strobe
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [CODE_W-1:0] PARK = CODE_W'(PARK_CODE);

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state, state_n;
    logic [CODE_W-1:0]    code_tbl  [DEPTH];
    logic [DWELL_W-1:0]   dwell_tbl [DEPTH];
    logic [DWELL_W-1:0]   cnt, cnt_n;
    logic [LW-1:0]        len, len_n;
    logic [CODE_W-1:0]    freq_n;
    logic                 busy_n, done_n, strobe_n;
    logic [AW-1:0]        idx_n;
    logic                 load;
    logic [AW-1:0]        load_idx;
    logic                 last_entry;

    // Table is only writable while idle, so RUN-time reads always see a stable table.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                code_tbl[i]  <= '0;
                dwell_tbl[i] <= '0;
            end
        end else if (cfg_we && state == IDLE) begin
            code_tbl[cfg_addr]  <= cfg_code;
            dwell_tbl[cfg_addr] <= cfg_dwell;
        end
    end

    assign last_entry = ({1'b0, step_idx} == (len - LW'(1)));

    always_comb begin
        state_n  = state;
        freq_n   = freq_value;
        busy_n   = busy;
        done_n   = 1'b0;
        strobe_n = 1'b0;
        idx_n    = step_idx;
        cnt_n    = cnt;
        len_n    = len;
        load     = 1'b0;
        load_idx = '0;

        case (state)
            IDLE: begin
                freq_n = PARK;
                busy_n = 1'b0;
                idx_n  = '0;
                if (start && !stop && cfg_len != '0) begin
                    len_n    = (cfg_len > LW'(DEPTH)) ? LW'(DEPTH) : cfg_len;
                    state_n  = RUN;
                    load     = 1'b1;
                    load_idx = '0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_n = IDLE;
                    freq_n  = PARK;
                    busy_n  = 1'b0;
                    idx_n   = '0;
                end else if (cnt != '0) begin
                    cnt_n = cnt - DWELL_W'(1);
                end else if (!last_entry) begin
                    load     = 1'b1;
                    load_idx = step_idx + AW'(1);
                end else if (loop) begin
                    load     = 1'b1;
                    load_idx = '0;
                end else begin
                    state_n = IDLE;
                    freq_n  = PARK;
                    busy_n  = 1'b0;
                    idx_n   = '0;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Entry load: a D-valued dwell counts D..0, giving D+1 cycles on the output.
        if (load) begin
            freq_n   = code_tbl[load_idx];
            cnt_n    = dwell_tbl[load_idx];
            idx_n    = load_idx;
            strobe_n = 1'b1;
            busy_n   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            len         <= '0;
            freq_value  <= PARK;
            busy        <= 1'b0;
            done        <= 1'b0;
            step_idx    <= '0;
            step_strobe <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            len         <= len_n;
            freq_value  <= freq_n;
            busy        <= busy_n;
            done        <= done_n;
            step_idx    <= idx_n;
            step_strobe <= strobe_n;
        end
    end
endmodule
